fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 10'd0, PC value loaded on reset.
REQ-002 Parameter: STACK_DEPTH, 4, return-address stack entries (2..8).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: stall  input  1  hold all state (PC, IR, stack) this cycle.
REQ-006 Port: jump  input  1  redirect PC to jump_addr.
REQ-007 Port: call  input  1  push PC+1, redirect PC to jump_addr.
REQ-008 Port: ret  input  1  pop stack top into PC.
REQ-009 Port: jump_addr  input  10  redirect target for jump/call.
REQ-010 Port: instr  input  16  instruction word read combinationally from program memory at pc.
REQ-011 Port: pc  output  10  registered program counter; drives program memory address.
REQ-012 Port: ir  output  16  registered instruction for decode.
REQ-013 Port: ir_valid  output  1  ir holds a real fetched instruction.
REQ-014 Port: stack_empty  output  1  stack holds 0 entries.
REQ-015 Port: stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-016 Port: stack_err  output  1  sticky over/underflow flag.

Function
REQ-017 Control priority per cycle SHALL be: stall > ret > call > jump > sequential increment; lower-priority requests in the same cycle SHALL be ignored.
REQ-018 Sequential: pc SHALL become pc+1 modulo 1024 (1023 -> 0), ir SHALL capture instr, ir_valid SHALL become 1.
REQ-019 stall=1: pc, ir, ir_valid, stack pointer and stack contents SHALL hold; redirects in that cycle SHALL be dropped.
REQ-020 jump: pc SHALL become jump_addr next cycle.
REQ-021 call, stack not full: stack SHALL push (pc+1) mod 1024; pc SHALL become jump_addr.
REQ-022 call, stack full: no push, stack contents unchanged, pc SHALL become jump_addr, stack_err SHALL set.
REQ-023 ret, stack not empty: pc SHALL become top entry; entry SHALL pop.
REQ-024 ret, stack empty: pc SHALL take sequential increment, stack_err SHALL set.
REQ-025 Any taken redirect (jump, call, ret, including faulted ones of REQ-022/024): ir SHALL load 16'h0000 (NOP) and ir_valid SHALL be 0 for that one cycle (wrong-path flush).
REQ-026 Latency: instruction at address A SHALL appear on ir one cycle after pc=A with no stall and no redirect.
REQ-027 stack_empty/stack_full SHALL be registered functions of stack pointer, valid same cycle as pointer.
REQ-028 stack_err SHALL remain 1 until reset.

Reset
REQ-029 reset_n=0 SHALL immediately force pc=RESET_PC, ir=16'h0000, ir_valid=0, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0, regardless of clk.
REQ-030 Reset asserted mid-call/ret SHALL discard the operation; stack entry contents need not be cleared.
REQ-031 First rising edge after reset_n deasserts SHALL perform a normal fetch from RESET_PC.

Structure
REQ-032 Shared package SHALL hold PC_W=10, INSTR_W=16, NOP=16'h0000.
REQ-033 Return-address LIFO SHALL be a sub-module ret_stack (push, pop, top, empty, full, parameterised depth); pc/ir/priority logic stays in fetch_unit.

Verification
REQ-034 Reset, 4 idle cycles, instr=mem[pc] -> pc 0,1,2,3,4; ir_valid 0 then 1; ir = mem[0..3].
REQ-035 pc=1023, no controls -> pc=0, no error.
REQ-036 At pc=10 call jump_addr=100; later ret -> pc 100, ir=NOP/ir_valid=0 one cycle; ret gives pc=11, stack_empty=1.
REQ-037 5 calls with STACK_DEPTH=4 -> stack_full=1 after 4th, stack_err=1 on 5th, 4 rets return last 4 pushed addresses in LIFO order.
REQ-038 stall=1 with jump=1 for 3 cycles -> pc, ir unchanged, jump dropped; ret on empty stack -> pc+1, stack_err=1.
REQ-039 reset_n pulsed low mid-cycle during call -> outputs reset asynchronously, no push, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and control decode for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int PC_W = 10;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_SEQ,
        ACT_JUMP,
        ACT_CALL,
        ACT_RET
    } action_e;

    // Resolves simultaneous requests: stall > ret > call > jump > sequential.
    function automatic action_e next_action(input logic stall, input logic ret,
                                            input logic call, input logic jump);
        if (stall)     return ACT_HOLD;
        else if (ret)  return ACT_RET;
        else if (call) return ACT_CALL;
        else if (jump) return ACT_JUMP;
        else           return ACT_SEQ;
    endfunction

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Return-address LIFO; overflowing pushes and underflowing pops are ignored.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] DEPTH_L = SPW'(DEPTH);

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_dec;
    logic [SPW-1:0] sp_next;
    logic           do_push;
    logic           do_pop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty && !do_push;
        sp_dec  = sp - 1'b1;
        sp_next = sp;
        if (do_push)
            sp_next = sp + 1'b1;
        else if (do_pop)
            sp_next = sp_dec;
    end

    assign top = mem[sp_dec[AW-1:0]];

    // Flags are registered from the next pointer so they change on the same edge as sp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp    <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            sp    <= sp_next;
            empty <= (sp_next == '0);
            full  <= (sp_next == DEPTH_L);
        end
    end

    // NOTE: entry storage has no reset; the pointer alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[sp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction register and redirect priority with a return-address stack.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 10'd0,
    parameter int              STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               jump,
    input  logic               call,
    input  logic               ret,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               stack_empty,
    output logic               stack_full,
    output logic               stack_err
);

    action_e         act;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stack_top;
    logic            push;
    logic            pop;

    always_comb begin
        act    = next_action(stall, ret, call, jump);
        pc_inc = pc + 1'b1;
        push   = (act == ACT_CALL) && !stack_full;
        pop    = (act == ACT_RET) && !stack_empty;
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top     (stack_top),
        .empty   (stack_empty),
        .full    (stack_full)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            ir        <= NOP;
            ir_valid  <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            case (act)
                ACT_HOLD: ;
                ACT_SEQ: begin
                    pc       <= pc_inc;
                    ir       <= instr;
                    ir_valid <= 1'b1;
                end
                ACT_JUMP: begin
                    pc       <= jump_addr;
                    ir       <= NOP;
                    ir_valid <= 1'b0;
                end
                ACT_CALL: begin
                    pc       <= jump_addr;
                    ir       <= NOP;
                    ir_valid <= 1'b0;
                    if (stack_full)
                        stack_err <= 1'b1;
                end
                ACT_RET: begin
                    // An empty-stack return still flushes the wrong-path word but falls through.
                    pc       <= stack_empty ? pc_inc : stack_top;
                    ir       <= NOP;
                    ir_valid <= 1'b0;
                    if (stack_empty)
                        stack_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               stall = 1'b0;
    logic               jump = 1'b0;
    logic               call = 1'b0;
    logic               ret = 1'b0;
    logic [PC_W-1:0]    jump_addr = '0;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               stack_empty;
    logic               stack_full;
    logic               stack_err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int             m_pc;
    logic [15:0]    m_ir;
    bit             m_valid;
    bit             m_err;
    int             m_stk[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC    (10'd0),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
        .jump_addr   (jump_addr),
        .instr       (instr),
        .pc          (pc),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    // Program memory image: word at address a is {6'h2A, a}.
    function automatic logic [15:0] mem_word(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {6'h2A, a10};
    endfunction

    assign instr = mem_word(int'(pc));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("ir", 32'(ir), 32'(m_ir));
            check("ir_valid", 32'(ir_valid), 32'(m_valid));
            check("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
            check("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
            check("stack_err", 32'(stack_err), 32'(m_err));
        end
    end

    task automatic model_reset();
        m_pc    = 0;
        m_ir    = 16'h0000;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_update(input bit s, input bit j, input bit c, input bit r, input int ja);
        if (s) return;
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = (m_pc + 1) % 1024;
                m_err = 1'b1;
            end
            m_ir = 16'h0000; m_valid = 1'b0;
        end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 1024);
            else m_err = 1'b1;
            m_pc = ja % 1024;
            m_ir = 16'h0000; m_valid = 1'b0;
        end else if (j) begin
            m_pc = ja % 1024;
            m_ir = 16'h0000; m_valid = 1'b0;
        end else begin
            m_ir    = mem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % 1024;
        end
    endtask

    task automatic step(input bit s, input bit j, input bit c, input bit r, input int ja);
        stall     = s;
        jump      = j;
        call      = c;
        ret       = r;
        jump_addr = ja[9:0];
        @(posedge clk);
        model_update(s, j, c, r, ja);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic assert_reset();
        check_en = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_stack_empty", 32'(stack_empty), 32'h1);
        check("rst_stack_full", 32'(stack_full), 32'h0);
        check("rst_stack_err", 32'(stack_err), 32'h0);
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        reset_n  = 1'b1;
        check_en = 1'b1;
    endtask

    initial begin
        #2;
        assert_reset();
        release_reset();

        // Straight-line fetch from reset.
        idle();
        check("first_pc", 32'(pc), 32'd1);
        check("first_ir", 32'(ir), 32'hA800);
        check("first_valid", 32'(ir_valid), 32'h1);
        repeat (3) idle();
        check("seq_pc", 32'(pc), 32'd4);
        check("seq_ir", 32'(ir), 32'hA803);

        // Wrap from the last address.
        step(0, 1, 0, 0, 1023);
        check("jump_flush", 32'(ir_valid), 32'h0);
        idle();
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_ir", 32'(ir), 32'hABFF);
        check("wrap_err", 32'(stack_err), 32'h0);

        // Call / return pair.
        step(0, 1, 0, 0, 10);
        step(0, 0, 1, 0, 100);
        check("call_pc", 32'(pc), 32'd100);
        check("call_ir", 32'(ir), 32'h0);
        check("call_valid", 32'(ir_valid), 32'h0);
        idle();
        idle();
        check("callee_ir", 32'(ir), 32'hA865);
        step(0, 0, 0, 1, 0);
        check("ret_pc", 32'(pc), 32'd11);
        check("ret_empty", 32'(stack_empty), 32'h1);

        // Fill, overflow, then unwind in LIFO order.
        step(0, 0, 1, 0, 200);
        step(0, 0, 1, 0, 300);
        step(0, 0, 1, 0, 400);
        check("not_full_3", 32'(stack_full), 32'h0);
        step(0, 0, 1, 0, 500);
        check("full_4", 32'(stack_full), 32'h1);
        check("no_err_4", 32'(stack_err), 32'h0);
        step(0, 0, 1, 0, 600);
        check("ovf_err", 32'(stack_err), 32'h1);
        check("ovf_pc", 32'(pc), 32'd600);
        step(0, 0, 0, 1, 0);
        check("lifo_0", 32'(pc), 32'd401);
        step(0, 0, 0, 1, 0);
        check("lifo_1", 32'(pc), 32'd301);
        step(0, 0, 0, 1, 0);
        check("lifo_2", 32'(pc), 32'd201);
        step(0, 0, 0, 1, 0);
        check("lifo_3", 32'(pc), 32'd12);
        check("lifo_empty", 32'(stack_empty), 32'h1);

        // Priority: call beats jump, ret beats call and jump.
        idle();
        step(0, 1, 1, 0, 40);
        check("call_over_jump", 32'(pc), 32'd40);
        step(0, 1, 1, 1, 77);
        check("ret_over_all", 32'(pc), 32'd14);

        // Stall drops redirects; empty-stack ret falls through and flags.
        assert_reset();
        release_reset();
        idle();
        idle();
        repeat (3) step(1, 1, 0, 0, 300);
        check("stall_pc", 32'(pc), 32'd2);
        check("stall_ir", 32'(ir), 32'hA801);
        check("stall_valid", 32'(ir_valid), 32'h1);
        step(0, 0, 0, 1, 0);
        check("unf_pc", 32'(pc), 32'd3);
        check("unf_err", 32'(stack_err), 32'h1);
        check("unf_valid", 32'(ir_valid), 32'h0);
        idle();
        check("err_sticky", 32'(stack_err), 32'h1);

        // Asynchronous reset in the middle of a call.
        call      = 1'b1;
        jump_addr = 10'd50;
        #2;
        assert_reset();
        release_reset();
        idle();
        check("post_rst_pc", 32'(pc), 32'd1);
        check("post_rst_empty", 32'(stack_empty), 32'h1);
        check("post_rst_ir", 32'(ir), 32'hA800);
        idle();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
